// File: rtl/vco_mmd_counter.sv
// Fractional-N multi-modulus divider counter.
// Divides CKVCNT by DIVN (clamped to MIN_DIV) plus a first-order sigma-delta
// carry from a FRAC_W-bit phase accumulator. The ratio is latched only at
// period load, so CKOUT periods are always complete and glitch-free.
module vco_mmd_counter #(
  parameter int WIDTH   = 8,
  parameter int FRAC_W  = 8,
  parameter int MIN_DIV = 4
) (
  input  logic              CKVCNT,
  input  logic              NRST,
  input  logic              EN,
  input  logic [WIDTH-1:0]  DIVN,
  input  logic [FRAC_W-1:0] FRAC,
  output logic              CKOUT,
  output logic              TC,
  output logic [WIDTH:0]    CNT,
  output logic [WIDTH:0]    PER
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH:0] MIN_DIV_W = (WIDTH+1)'(MIN_DIV);
  localparam logic [WIDTH:0] ONE_W     = (WIDTH+1)'(1);

  state_t              state_q, state_d;
  logic [WIDTH:0]      cnt_q, cnt_d;
  logic [WIDTH:0]      per_q, per_d;
  logic                ckout_q, ckout_d;
  logic                tc_q, tc_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;

  logic                load;
  logic [WIDTH:0]      nc;
  logic [FRAC_W:0]     acc_sum;
  logic [WIDTH:0]      p_len;
  logic [WIDTH:0]      p_m1;
  logic [WIDTH:0]      cnt_m1;

  // State register and datapath flops; reset clears everything including ACC.
  always_ff @(posedge CKVCNT or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      ckout_q <= 1'b0;
      tc_q    <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ckout_q <= ckout_d;
      tc_q    <= tc_d;
      acc_q   <= acc_d;
    end
  end

  // Next state: a load happens on leaving IDLE or at the end of a period
  // while enabled; dropping EN only takes effect at the period end.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (EN) load = 1'b1;
          else    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period arithmetic: clamped ratio plus accumulator carry, kept one bit
  // wider than DIVN so 2^WIDTH-1 plus a carry still fits.
  always_comb begin
    nc      = ({1'b0, DIVN} < MIN_DIV_W) ? MIN_DIV_W : {1'b0, DIVN};
    acc_sum = {1'b0, acc_q} + {1'b0, FRAC};
    p_len   = nc + {{WIDTH{1'b0}}, acc_sum[FRAC_W]};
    p_m1    = p_len - ONE_W;
    cnt_m1  = cnt_q - ONE_W;
  end

  // Output/datapath next values: load, count down, or fall back to idle zeros.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    ckout_d = ckout_q;
    tc_d    = tc_q;
    acc_d   = acc_q;
    if (load) begin
      acc_d   = acc_sum[FRAC_W-1:0];
      per_d   = p_len;
      cnt_d   = p_m1;
      ckout_d = 1'b1;
      tc_d    = (p_m1 == '0);
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d   = cnt_m1;
        // High for the first ceil(P/2) cycles, low for the remaining floor(P/2).
        ckout_d = (cnt_m1 >= (per_q >> 1));
        tc_d    = (cnt_m1 == '0);
      end else begin
        cnt_d   = '0;
        per_d   = '0;
        ckout_d = 1'b0;
        tc_d    = 1'b0;
      end
    end
  end

  assign CKOUT = ckout_q;
  assign TC    = tc_q;
  assign CNT   = cnt_q;
  assign PER   = per_q;

endmodule

// File: tb/tb_vco_mmd_counter.sv
// Bench for vco_mmd_counter: a period-level model (period length, position
// within the period, accumulator as an integer) is compared against the DUT
// every cycle, plus literal expectations for the directed scenarios.
module tb_vco_mmd_counter;

  logic       CKVCNT = 1'b0;
  logic       NRST   = 1'b0;
  logic       EN     = 1'b0;
  logic [7:0] DIVN   = 8'd4;
  logic [7:0] FRAC   = 8'd0;
  logic       CKOUT, TC;
  logic [8:0] CNT, PER;

  vco_mmd_counter #(.WIDTH(8), .FRAC_W(8), .MIN_DIV(4)) dut (
    .CKVCNT(CKVCNT), .NRST(NRST), .EN(EN), .DIVN(DIVN), .FRAC(FRAC),
    .CKOUT(CKOUT), .TC(TC), .CNT(CNT), .PER(PER)
  );

  always #5 CKVCNT = ~CKVCNT;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: period length P, position pos in 0..P-1, accumulator as an integer.
  int m_run = 0, m_pos = 0, m_per = 0, m_acc = 0, m_s = 0;

  initial forever begin
    @(posedge CKVCNT or negedge NRST);
    if (!NRST) begin
      m_run = 0; m_pos = 0; m_per = 0; m_acc = 0;
    end else if (m_run == 0 || m_pos == m_per - 1) begin
      if (EN) begin
        m_s   = m_acc + int'(FRAC);
        m_acc = m_s % 256;
        m_per = ((int'(DIVN) < 4) ? 4 : int'(DIVN)) + m_s / 256;
        m_pos = 0;
        m_run = 1;
      end else begin
        m_run = 0;
      end
    end else begin
      m_pos++;
    end
  end

  // Per-cycle compare against the model.
  int e_cnt, e_per, e_ck, e_tc;
  initial forever begin
    @(negedge CKVCNT);
    if (chk_on) begin
      if (m_run == 0) begin
        e_cnt = 0; e_per = 0; e_ck = 0; e_tc = 0;
      end else begin
        e_cnt = m_per - 1 - m_pos;
        e_per = m_per;
        e_ck  = (m_pos < (m_per + 1) / 2) ? 1 : 0;
        e_tc  = (m_pos == m_per - 1) ? 1 : 0;
      end
      chk("cyc_cnt",   int'(CNT),   e_cnt);
      chk("cyc_per",   int'(PER),   e_per);
      chk("cyc_ckout", int'(CKOUT), e_ck);
      chk("cyc_tc",    int'(TC),    e_tc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input int c, input int p);
    for (int k = 0; k < 3000; k++) begin
      @(negedge CKVCNT);
      if (int'(CNT) == c && int'(PER) == p) return;
    end
    chk("wait_timeout", 0, 1);
  endtask

  logic [15:0] pat;
  int cseq, tcs, cyc, pseq, mx, seen;

  initial begin
    // Reset
    NRST = 1'b0;
    repeat (2) @(posedge CKVCNT);
    #2 NRST = 1'b1;
    chk_on = 1;
    @(negedge CKVCNT);
    chk("rst_cnt", int'(CNT), 0);
    chk("rst_per", int'(PER), 0);
    chk("rst_ckout", int'(CKOUT), 0);

    // DIVN=4: first CKOUT rise on the edge that samples EN
    @(posedge CKVCNT); #2;
    EN = 1'b1; DIVN = 8'd4; FRAC = 8'd0;
    @(posedge CKVCNT);
    pat = '0; cseq = 0; tcs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CKVCNT);
      pat = {pat[14:0], CKOUT};
      if (i < 4) cseq = (cseq << 4) | int'(CNT);
      tcs += int'(TC);
    end
    chk("div4_ckout", int'(pat[7:0]), 'hCC);
    chk("div4_cnt",   cseq, 'h3210);
    chk("div4_tc",    tcs, 2);
    chk("div4_per",   int'(PER), 4);

    // DIVN=5
    #1 DIVN = 8'd5;
    wait_state(4, 5);
    pat = {15'd0, CKOUT}; cseq = int'(CNT); tcs = int'(TC);
    for (int i = 1; i < 10; i++) begin
      @(negedge CKVCNT);
      pat = {pat[14:0], CKOUT};
      if (i < 5) cseq = (cseq << 4) | int'(CNT);
      tcs += int'(TC);
    end
    chk("div5_ckout", int'(pat[9:0]), 'h39C);
    chk("div5_cnt",   cseq, 'h43210);
    chk("div5_tc",    tcs, 2);

    // DIVN=2 clamps to 4
    #1 DIVN = 8'd2;
    wait_state(3, 4);
    pat = {15'd0, CKOUT};
    for (int i = 1; i < 4; i++) begin
      @(negedge CKVCNT);
      pat = {pat[14:0], CKOUT};
    end
    chk("clamp_ckout", int'(pat[3:0]), 'hC);

    // Ratio change mid-period waits for the next load
    wait_state(2, 4);
    #1 DIVN = 8'd6;
    @(negedge CKVCNT);
    chk("switch_hold_per", int'(PER), 4);
    wait_state(5, 6);
    pat = {15'd0, CKOUT};
    for (int i = 1; i < 6; i++) begin
      @(negedge CKVCNT);
      pat = {pat[14:0], CKOUT};
    end
    chk("div6_ckout", int'(pat[5:0]), 'h38);

    // EN dropped at CNT=2: period completes, then idle zeros
    wait_state(2, 6);
    #1 EN = 1'b0;
    @(negedge CKVCNT); chk("endrop_cnt1", int'(CNT), 1);
    @(negedge CKVCNT); chk("endrop_cnt0", int'(CNT), 0); chk("endrop_tc", int'(TC), 1);
    @(negedge CKVCNT);
    chk("idle_per", int'(PER), 0);
    chk("idle_ckout", int'(CKOUT), 0);
    repeat (3) @(negedge CKVCNT);

    // Restart with a fractional word; model tracks the retained ACC
    #1 EN = 1'b1; DIVN = 8'd6; FRAC = 8'd37;
    repeat (50) @(negedge CKVCNT);

    // Async reset mid-period
    wait_state(3, 6);
    #1 NRST = 1'b0;
    #1;
    chk("arst_ckout", int'(CKOUT), 0);
    chk("arst_tc",    int'(TC), 0);
    chk("arst_cnt",   int'(CNT), 0);
    chk("arst_per",   int'(PER), 0);
    DIVN = 8'd8; FRAC = 8'd64;
    @(posedge CKVCNT); #2 NRST = 1'b1;

    // DIVN=8 FRAC=0.25 from ACC=0: 8,8,8,9 and 400 periods = 3300 cycles
    @(posedge CKVCNT);
    cyc = 0; tcs = 0; pseq = 0;
    while (tcs < 400 && cyc < 5000) begin
      @(negedge CKVCNT);
      cyc++;
      if (TC) begin
        if (tcs < 4) pseq = (pseq << 8) | int'(PER);
        tcs++;
      end
    end
    chk("frac_pseq",   pseq, 'h08080809);
    chk("frac_cycles", cyc, 3300);

    // Max ratio with carry: PER reaches 256, CNT reaches 255
    @(posedge CKVCNT); #2 DIVN = 8'd255; FRAC = 8'd255;
    mx = 0; seen = 0;
    for (int i = 0; i < 2600; i++) begin
      @(negedge CKVCNT);
      if (int'(CNT) > mx) mx = int'(CNT);
      if (int'(PER) == 256) seen = 1;
    end
    chk("max_per256", seen, 1);
    chk("max_cnt",    mx, 255);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(posedge CKVCNT); #2;
      if ($urandom_range(0, 7) == 0)
        DIVN = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255))
                                             : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) FRAC = 8'($urandom);
      if ($urandom_range(0, 39) == 0) EN = ~EN;
      if ($urandom_range(0, 499) == 0) begin
        NRST = 1'b0;
        #4 NRST = 1'b1;
      end
    end

    @(negedge CKVCNT);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
